// File: rtl/gcm_block_feeder.sv
// Packs a 32-bit AAD/PT word stream into 128-bit GCM core blocks, masking and
// zero-padding segment tails, then waits for the core's tag with a timeout.
module gcm_block_feeder #(
    parameter int unsigned TAG_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [15:0]  i_aad_len,
    input  logic [15:0]  i_pt_len,
    input  logic [31:0]  i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [127:0] o_block,
    output logic         o_block_valid,
    output logic         o_new_instance,
    output logic         o_pt_instance,
    output logic [63:0]  o_aad_size,
    output logic [63:0]  o_pt_size,
    input  logic         i_tag_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_timeout
);
    localparam int unsigned CW = (TAG_TIMEOUT > 1) ? $clog2(TAG_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, AAD_FILL, PT_FILL, EMIT, WAIT_TAG} state_t;

    state_t         r_state;
    logic [127:0]   r_buf;
    logic [1:0]     r_idx;
    logic [14:0]    r_left;
    logic [1:0]     r_rem;
    logic [14:0]    r_pt_words;
    logic [1:0]     r_pt_rem;
    logic           r_in_pt;
    logic           r_msg_first;
    logic           r_seg_first;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_block;
    logic           r_block_valid;
    logic           r_new;
    logic           r_pt_inst;
    logic [63:0]    r_aad_size;
    logic [63:0]    r_pt_size;
    logic           r_done;
    logic           r_timeout;

    logic [14:0]    w_aad_words;
    logic [14:0]    w_pt_words;
    logic           w_last_word;
    logic [31:0]    w_mask;
    logic [31:0]    w_word;
    logic [127:0]   w_asm;

    assign w_aad_words = {1'b0, i_aad_len[15:2]} + {14'd0, |i_aad_len[1:0]};
    assign w_pt_words  = {1'b0, i_pt_len[15:2]}  + {14'd0, |i_pt_len[1:0]};
    assign w_last_word = (r_left == 15'd1);

    // Only the final word of a segment can carry bytes past the segment length.
    always_comb begin
        w_mask = '1;
        if (w_last_word) begin
            case (r_rem)
                2'd1:    w_mask = 32'hFF00_0000;
                2'd2:    w_mask = 32'hFFFF_0000;
                2'd3:    w_mask = 32'hFFFF_FF00;
                default: w_mask = '1;
            endcase
        end
        w_word = i_data & w_mask;
        w_asm  = r_buf;
        case (r_idx)
            2'd0:    w_asm[127:96] = w_word;
            2'd1:    w_asm[95:64]  = w_word;
            2'd2:    w_asm[63:32]  = w_word;
            default: w_asm[31:0]   = w_word;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_buf         <= '0;
            r_idx         <= '0;
            r_left        <= '0;
            r_rem         <= '0;
            r_pt_words    <= '0;
            r_pt_rem      <= '0;
            r_in_pt       <= 1'b0;
            r_msg_first   <= 1'b0;
            r_seg_first   <= 1'b0;
            r_cnt         <= '0;
            r_block       <= '0;
            r_block_valid <= 1'b0;
            r_new         <= 1'b0;
            r_pt_inst     <= 1'b0;
            r_aad_size    <= '0;
            r_pt_size     <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_block_valid <= 1'b0;
            r_new         <= 1'b0;
            r_pt_inst     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_aad_size  <= {45'd0, i_aad_len, 3'd0};
                        r_pt_size   <= {45'd0, i_pt_len, 3'd0};
                        r_pt_words  <= w_pt_words;
                        r_pt_rem    <= i_pt_len[1:0];
                        r_buf       <= '0;
                        r_idx       <= '0;
                        r_msg_first <= 1'b1;
                        r_seg_first <= 1'b1;
                        if (i_aad_len != 16'd0) begin
                            r_left  <= w_aad_words;
                            r_rem   <= i_aad_len[1:0];
                            r_in_pt <= 1'b0;
                            r_state <= AAD_FILL;
                        end else if (i_pt_len != 16'd0) begin
                            r_left  <= w_pt_words;
                            r_rem   <= i_pt_len[1:0];
                            r_in_pt <= 1'b1;
                            r_state <= PT_FILL;
                        end else begin
                            r_left        <= '0;
                            r_in_pt       <= 1'b1;
                            r_block       <= '0;
                            r_block_valid <= 1'b1;
                            r_new         <= 1'b1;
                            r_pt_inst     <= 1'b1;
                            r_msg_first   <= 1'b0;
                            r_seg_first   <= 1'b0;
                            r_state       <= EMIT;
                        end
                    end
                end
                AAD_FILL, PT_FILL: begin
                    if (i_valid) begin
                        r_left <= r_left - 15'd1;
                        if (r_idx == 2'd3 || w_last_word) begin
                            r_block       <= w_asm;
                            r_block_valid <= 1'b1;
                            r_new         <= r_msg_first;
                            r_pt_inst     <= r_in_pt & r_seg_first;
                            r_msg_first   <= 1'b0;
                            r_seg_first   <= 1'b0;
                            r_buf         <= '0;
                            r_idx         <= '0;
                            r_state       <= EMIT;
                        end else begin
                            r_buf <= w_asm;
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                EMIT: begin
                    if (r_left != 15'd0) begin
                        r_state <= r_in_pt ? PT_FILL : AAD_FILL;
                    end else if (!r_in_pt && r_pt_words != 15'd0) begin
                        r_left      <= r_pt_words;
                        r_rem       <= r_pt_rem;
                        r_in_pt     <= 1'b1;
                        r_seg_first <= 1'b1;
                        r_state     <= PT_FILL;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= WAIT_TAG;
                    end
                end
                WAIT_TAG: begin
                    if (i_tag_ready) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_cnt == CW'(TAG_TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready        = (r_state == AAD_FILL) || (r_state == PT_FILL);
    assign o_busy         = (r_state != IDLE);
    assign o_block        = r_block;
    assign o_block_valid  = r_block_valid;
    assign o_new_instance = r_new;
    assign o_pt_instance  = r_pt_inst;
    assign o_aad_size     = r_aad_size;
    assign o_pt_size      = r_pt_size;
    assign o_done         = r_done;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_gcm_block_feeder.sv
// Randomized bench for gcm_block_feeder: expected blocks are built from the
// byte streams directly (16-byte chunks, zero tail) and compared to strobes.
module tb_gcm_block_feeder;
    localparam int unsigned TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  aad_len;
    logic [15:0]  pt_len;
    logic [31:0]  data;
    logic         valid;
    logic         ready;
    logic [127:0] blk;
    logic         blk_valid;
    logic         new_inst;
    logic         pt_inst;
    logic [63:0]  aad_size;
    logic [63:0]  pt_size;
    logic         tag_ready;
    logic         busy;
    logic         done;
    logic         timeout;

    always #5 clk = ~clk;

    gcm_block_feeder #(.TAG_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_aad_len      (aad_len),
        .i_pt_len       (pt_len),
        .i_data         (data),
        .i_valid        (valid),
        .o_ready        (ready),
        .o_block        (blk),
        .o_block_valid  (blk_valid),
        .o_new_instance (new_inst),
        .o_pt_instance  (pt_inst),
        .o_aad_size     (aad_size),
        .o_pt_size      (pt_size),
        .i_tag_ready    (tag_ready),
        .o_busy         (busy),
        .o_done         (done),
        .o_timeout      (timeout)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [127:0] obs_blk[$];
    logic         obs_new[$];
    logic         obs_pt[$];
    logic [127:0] exp_blk[$];
    logic         exp_new[$];
    logic         exp_pt[$];
    logic [31:0]  aad_w[$];
    logic [31:0]  pt_w[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (blk_valid === 1'b1) begin
            obs_blk.push_back(blk);
            obs_new.push_back(new_inst);
            obs_pt.push_back(pt_inst);
        end else begin
            check_eq("stray_flags", {126'd0, new_inst, pt_inst}, 128'd0);
        end
    end

    task automatic fill_random(input int unsigned alen, input int unsigned plen);
        aad_w.delete();
        pt_w.delete();
        for (int unsigned i = 0; i < (alen + 3) / 4; i++) aad_w.push_back($urandom);
        for (int unsigned i = 0; i < (plen + 3) / 4; i++) pt_w.push_back($urandom);
    endtask

    task automatic model(input int unsigned alen, input int unsigned plen);
        logic [127:0] b;
        logic [31:0]  x;
        int unsigned  len;
        bit           first;
        exp_blk.delete();
        exp_new.delete();
        exp_pt.delete();
        if (alen == 0 && plen == 0) begin
            exp_blk.push_back('0);
            exp_new.push_back(1'b1);
            exp_pt.push_back(1'b1);
            return;
        end
        first = 1'b1;
        for (int s = 0; s < 2; s++) begin
            len = (s == 0) ? alen : plen;
            for (int unsigned off = 0; off < len; off += 16) begin
                b = '0;
                for (int unsigned k = 0; k < 16; k++) begin
                    if (off + k < len) begin
                        x = (s == 0) ? aad_w[(off + k) / 4] : pt_w[(off + k) / 4];
                        b[127 - 8 * k -: 8] = x[31 - 8 * ((off + k) % 4) -: 8];
                    end
                end
                exp_blk.push_back(b);
                exp_new.push_back(first);
                exp_pt.push_back(s == 1 && off == 0);
                first = 1'b0;
            end
        end
    endtask

    // tag_delay < 0 lets the wait for the tag expire.
    task automatic run_msg(input int unsigned alen, input int unsigned plen,
                           input int tag_delay, input bit poke_start);
        logic [31:0] words[$];
        int unsigned idx;
        int unsigned cyc;
        int unsigned n;
        words.delete();
        foreach (aad_w[i]) words.push_back(aad_w[i]);
        foreach (pt_w[i]) words.push_back(pt_w[i]);
        model(alen, plen);
        obs_blk.delete();
        obs_new.delete();
        obs_pt.delete();

        @(negedge clk);
        start   = 1'b1;
        aad_len = 16'(alen);
        pt_len  = 16'(plen);
        @(negedge clk);
        start   = 1'b0;
        aad_len = 16'($urandom);
        pt_len  = 16'($urandom);

        idx = 0;
        cyc = 0;
        while (idx < words.size() && cyc < 2000) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = valid ? words[idx] : $urandom;
            start = poke_start && (cyc == 3);
            if (valid && ready) idx++;
            @(negedge clk);
            cyc++;
        end
        check_eq("feed_words", idx, words.size());
        valid = 1'b0;
        start = 1'b0;

        cyc = 0;
        while (!(busy && !ready && !blk_valid) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_wait_tag", {127'd0, busy && !ready && !blk_valid}, 128'd1);
        check_eq("aad_size", aad_size, alen * 8);
        check_eq("pt_size", pt_size, plen * 8);

        check_eq("n_blocks", obs_blk.size(), exp_blk.size());
        for (int i = 0; i < obs_blk.size() && i < exp_blk.size(); i++) begin
            check_eq("block", obs_blk[i], exp_blk[i]);
            check_eq("new_instance", obs_new[i], exp_new[i]);
            check_eq("pt_instance", obs_pt[i], exp_pt[i]);
        end

        if (tag_delay < 0) begin
            n = 1;
            while (n <= TMO + 4) begin
                @(negedge clk);
                if (!busy) break;
                n++;
            end
            check_eq("wait_tag_cycles", n, TMO);
            check_eq("timeout_pulse", {done, timeout}, 2'b01);
        end else begin
            repeat (tag_delay) @(negedge clk);
            check_eq("busy_in_wait", busy, 1'b1);
            tag_ready = 1'b1;
            @(negedge clk);
            tag_ready = 1'b0;
            check_eq("done_pulse", {done, timeout}, 2'b10);
            check_eq("idle_after_done", busy, 1'b0);
        end
        @(negedge clk);
        check_eq("pulse_one_cycle", {done, timeout}, 2'b00);
    endtask

    task automatic reset_midway();
        int unsigned idx;
        int unsigned cyc;
        fill_random(64, 0);
        @(negedge clk);
        start   = 1'b1;
        aad_len = 16'd64;
        pt_len  = 16'd0;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 100) begin
            valid = 1'b1;
            data  = aad_w[idx];
            if (ready) idx++;
            @(negedge clk);
            cyc++;
        end
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_state", {124'd0, busy, ready, blk_valid, new_inst}, 128'd0);
        check_eq("rst_async_block", blk, 128'd0);
        check_eq("rst_async_sizes", {aad_size, pt_size}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_rst", {126'd0, busy, ready}, 128'd0);
        fill_random(16, 0);
        run_msg(16, 0, 3, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned alen;
        int unsigned plen;
        int          dly;
        rst_n     = 1'b0;
        start     = 1'b0;
        aad_len   = '0;
        pt_len    = '0;
        data      = '0;
        valid     = 1'b0;
        tag_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_block", blk, 128'd0);
        check_eq("reset_sizes", {aad_size, pt_size}, 128'd0);
        check_eq("reset_ctrl", {121'd0, busy, ready, blk_valid, new_inst, pt_inst, done, timeout}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_random(64, 64);
        run_msg(64, 64, 5, 1'b0);

        fill_random(20, 0);
        run_msg(20, 0, 2, 1'b1);

        aad_w.delete();
        pt_w.delete();
        pt_w.push_back(32'h1122_3344);
        pt_w.push_back(32'h5566_7788);
        run_msg(0, 5, 0, 1'b0);
        if (obs_blk.size() > 0) check_eq("pt5_block", obs_blk[0], {40'h11_2233_4455, 88'd0});
        else check_eq("pt5_block_present", obs_blk.size(), 1);

        aad_w.delete();
        pt_w.delete();
        run_msg(0, 0, 1, 1'b0);

        fill_random(8, 4);
        run_msg(8, 4, -1, 1'b0);

        fill_random(4, 0);
        run_msg(4, 0, TMO - 1, 1'b0);

        reset_midway();

        for (int t = 0; t < 20; t++) begin
            alen = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 70);
            plen = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 70);
            dly  = (t % 6 == 5) ? -1 : int'($urandom_range(0, TMO - 1));
            fill_random(alen, plen);
            run_msg(alen, plen, dly, t[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcm_block_feeder.md
GCM_BLOCK_FEEDER -- requirements
Module: gcm_block_feeder

Interface
REQ-001 SHALL have parameter TAG_TIMEOUT, default 64, meaning the maximum number of cycles spent in WAIT_TAG before abort.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_start, input, 1 bit: one-cycle pulse that begins a message.
REQ-005 SHALL have port i_aad_len, input, 16 bits: AAD length in bytes, captured on i_start.
REQ-006 SHALL have port i_pt_len, input, 16 bits: plaintext length in bytes, captured on i_start.
REQ-007 SHALL have port i_data, input, 32 bits: stream word, first byte in bits [31:24]; all AAD words precede all PT words.
REQ-008 SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-009 SHALL have port o_ready, output, 1 bit: a word is accepted when i_valid && o_ready.
REQ-010 SHALL have port o_block, output, 128 bits: assembled block, first stream byte in bits [127:120]; drives the GCM core AAD and plaintext inputs.
REQ-011 SHALL have port o_block_valid, output, 1 bit: one-cycle strobe marking o_block valid.
REQ-012 SHALL have port o_new_instance, output, 1 bit: qualifies the first block of a message.
REQ-013 SHALL have port o_pt_instance, output, 1 bit: qualifies the first PT block.
REQ-014 SHALL have port o_aad_size, output, 64 bits: AAD length in bits.
REQ-015 SHALL have port o_pt_size, output, 64 bits: PT length in bits.
REQ-016 SHALL have port i_tag_ready, input, 1 bit: GCM core tag-ready indication.
REQ-017 SHALL have ports o_busy, o_done and o_timeout, outputs, 1 bit each: busy when not IDLE; done and timeout are one-cycle completion pulses.

Function
REQ-018 SHALL implement FSM states IDLE, AAD_FILL, PT_FILL, EMIT and WAIT_TAG.
REQ-019 On i_start in IDLE, SHALL capture both lengths, set o_aad_size=aad_len*8 and o_pt_size=pt_len*8 (zero-extended), and enter AAD_FILL; if aad_len==0, enter PT_FILL instead; if both are 0, enter EMIT with an all-zero block.
REQ-020 SHALL ignore i_start outside IDLE.
REQ-021 SHALL drive o_ready=1 only in AAD_FILL and PT_FILL, and ignore i_valid in all other states.
REQ-022 Segment word count SHALL be ceil(len/4).
REQ-023 In the last word of a segment, SHALL force bytes beyond len%4 (when nonzero) to 0x00.
REQ-024 A partial final block SHALL be zero-padded in the trailing word positions.
REQ-025 When the 4th word of a block, or the last word of a segment, is accepted, SHALL enter EMIT; the next cycle SHALL drive o_block_valid=1 for exactly one cycle with o_ready=0.
REQ-026 Block latency SHALL be 1 cycle from the completing handshake; throughput is 4 words per 5 cycles.
REQ-027 o_new_instance SHALL be 1 only with the first emitted block of the message.
REQ-028 o_pt_instance SHALL be 1 only with the first PT block.
REQ-029 With both lengths 0, both flags SHALL be set on the single zero block.
REQ-030 After EMIT, SHALL return to the same fill state if words remain in the segment, go AAD->PT_FILL when AAD ends and pt_len>0, and otherwise go to WAIT_TAG.
REQ-031 Block buffers SHALL clear after each emit, so AAD and PT never share a block.
REQ-032 On entry to WAIT_TAG, SHALL clear a cycle counter and then increment it each cycle.
REQ-033 In WAIT_TAG, i_tag_ready=1 SHALL pulse o_done and return to IDLE; i_tag_ready takes priority over timeout in the same cycle.
REQ-034 When the WAIT_TAG counter reaches TAG_TIMEOUT-1 without i_tag_ready, SHALL pulse o_timeout and return to IDLE.
REQ-035 Outside their pulse cycles, o_block_valid, o_new_instance, o_pt_instance, o_done and o_timeout SHALL be 0.
REQ-036 o_block SHALL hold its last value between strobes.

Reset
REQ-037 While i_rst_n=0, regardless of clk, SHALL force state to IDLE and all outputs to 0, including o_block, the size outputs and the counters.
REQ-038 Reset mid-message SHALL discard all partial data; after release, only a new i_start proceeds.

Verification
REQ-039 aad_len=64, pt_len=64, 32 words -> 8 strobes; new_instance on strobe 0 only; pt_instance on strobe 4 only; o_aad_size=o_pt_size=512.
REQ-040 aad_len=20, pt_len=0, 5 words -> 2 strobes; block 1 = word4 followed by 96 zero bits; WAIT_TAG; pt_instance never set.
REQ-041 aad_len=0, pt_len=5, words 0x11223344 and 0x55667788 -> one strobe, o_block=0x1122334455 followed by 88 zero bits, both flags set.
REQ-042 aad_len=0, pt_len=0 -> one all-zero block with both flags; then i_tag_ready on cycle 3 -> o_done pulse, IDLE.
REQ-043 TAG_TIMEOUT=64, i_tag_ready held 0 -> o_timeout on the 64th WAIT_TAG cycle; o_busy falls the next cycle.
REQ-044 i_rst_n low after 6 of 16 AAD words, then restart with aad_len=16, pt_len=0 -> exactly one strobe with new_instance=1, no stale bytes.
